// File: rtl/adc16dv160_input_capture.sv
// rtl/adc16dv160_input_capture.sv - ADC sample capture into a small FIFO emitted as an AXI4-Stream packet
module adc16dv160_input_capture #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [31:0]       dsize,
  input  logic              cr_test,
  input  logic              cr_start,
  output logic [DATA_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic              M_AXIS_TLAST,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [31:0]       sample_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  // Last free slot is kept for a forced TLAST entry so every packet terminates.
  localparam logic [AW:0] OCC_LIM = OW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       len_q, len_d;
  logic              mode_q, mode_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       occ_q, occ_d;
  logic [DATA_W:0]   mem_q [FIFO_DEPTH];

  logic              push, pop, push_last, is_final;
  logic [DATA_W-1:0] push_data;
  logic [AW:0]       occ_post;
  logic [DATA_W:0]   head;

  assign head          = mem_q[rd_ptr_q];
  assign M_AXIS_TVALID = (occ_q != '0);
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? head[DATA_W-1:0] : '0;
  assign M_AXIS_TLAST  = M_AXIS_TVALID & head[DATA_W];
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign ovf           = ovf_q;
  assign sample_cnt    = cnt_q;

  // Capture FSM next-state, status updates and FIFO pointer bookkeeping.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    push      = 1'b0;
    push_last = 1'b0;
    pop       = M_AXIS_TVALID & M_AXIS_TREADY;
    occ_post  = occ_q - OW'(pop);
    is_final  = (cnt_q == len_q - 32'd1);
    push_data = mode_q ? cnt_q[DATA_W-1:0] : adc_data;

    case (state_q)
      S_IDLE: begin
        if (cr_start) begin
          len_d  = dsize;
          mode_d = cr_test;
          ovf_d  = 1'b0;
          cnt_d  = '0;
          if (dsize == 32'd0) begin
            done_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            state_d = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (adc_valid) begin
          push  = 1'b1;
          cnt_d = cnt_q + 32'd1;
          if (is_final) begin
            push_last = 1'b1;
            state_d   = S_DRAIN;
          end else if (occ_post == OCC_LIM) begin
            push_last = 1'b1;
            ovf_d     = 1'b1;
            state_d   = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && head[DATA_W]) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // State and status registers; reset empties the FIFO and discards any packet.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // FIFO storage; contents are only observed through an occupied head slot.
  always_ff @(posedge ACLK) begin
    if (push) mem_q[wr_ptr_q] <= {push_last, push_data};
  end

endmodule

// File: tb/tb_adc16dv160_input_capture.sv
// tb/tb_adc16dv160_input_capture.sv - scoreboard bench for adc16dv160_input_capture
module tb_adc16dv160_input_capture;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic [31:0] dsize;
  logic        cr_test;
  logic        cr_start;
  logic [15:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic        M_AXIS_TLAST;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [31:0] sample_cnt;

  int errors = 0;
  int checks = 0;
  logic [16:0] sb[$];

  adc16dv160_input_capture #(.FIFO_DEPTH(8), .DATA_W(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .adc_data(adc_data), .adc_valid(adc_valid),
    .dsize(dsize), .cr_test(cr_test), .cr_start(cr_start),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
    .busy(busy), .done(done), .ovf(ovf), .sample_cnt(sample_cnt)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [15:0] d, input logic last);
    sb.push_back({last, d});
  endtask

  task automatic start(input logic [31:0] n, input logic test);
    @(posedge ACLK); #1;
    dsize = n; cr_test = test; cr_start = 1'b1;
    @(posedge ACLK); #1;
    cr_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge ACLK); #1;
      n++;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks AXIS hold rules.
  initial begin
    logic        prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;
    logic [16:0] exp;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!(M_AXIS_TVALID && M_AXIS_TDATA == prev_data && M_AXIS_TLAST == prev_last)) begin
            errors++;
            $display("FAIL hold: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                     M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, prev_data, prev_last);
          end
        end
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL beat: got unexpected beat %0h last=%0b expected none", M_AXIS_TDATA, M_AXIS_TLAST);
          end else begin
            exp = sb.pop_front();
            if ({M_AXIS_TLAST, M_AXIS_TDATA} !== exp) begin
              errors++;
              $display("FAIL beat: got last=%0b data=%0h expected last=%0b data=%0h",
                       M_AXIS_TLAST, M_AXIS_TDATA, exp[16], exp[15:0]);
            end
          end
        end
        prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
        prev_data  = M_AXIS_TDATA;
        prev_last  = M_AXIS_TLAST;
      end
    end
  end

  initial begin
    int k;
    ARESET = 1'b1; adc_data = '0; adc_valid = 1'b0; dsize = '0;
    cr_test = 1'b0; cr_start = 1'b0; M_AXIS_TREADY = 1'b0;
    #2;
    check("rst_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
    check("rst_tlast", {31'd0, M_AXIS_TLAST}, 32'd0);
    check("rst_tdata", {16'd0, M_AXIS_TDATA}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_cnt", sample_cnt, 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;

    // 1: four test-pattern beats, free-flowing
    adc_valid = 1'b1; M_AXIS_TREADY = 1'b1;
    expect_beat(16'd0, 1'b0); expect_beat(16'd1, 1'b0);
    expect_beat(16'd2, 1'b0); expect_beat(16'd3, 1'b1);
    start(32'd4, 1'b1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_done("t1_done", 50);
    check("t1_idle", {31'd0, busy}, 32'd0);
    check("t1_ovf", {31'd0, ovf}, 32'd0);
    check("t1_cnt", sample_cnt, 32'd4);
    check("t1_sb_empty", sb.size(), 32'd0);

    // 2: zero-length capture
    start(32'd0, 1'b1);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd0);
    check("t2_cnt", sample_cnt, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge ACLK); #1;
      check("t2_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
      check("t2_busy_hold", {31'd0, busy}, 32'd0);
    end

    // 3: overflow with sink stalled
    M_AXIS_TREADY = 1'b0;
    for (int i = 0; i < 8; i++) expect_beat(16'(i), i == 7);
    start(32'd100, 1'b1);
    for (int i = 0; i < 15; i++) begin
      @(posedge ACLK); #1;
    end
    check("t3_tvalid", {31'd0, M_AXIS_TVALID}, 32'd1);
    check("t3_head", {16'd0, M_AXIS_TDATA}, 32'd0);
    check("t3_head_last", {31'd0, M_AXIS_TLAST}, 32'd0);
    check("t3_ovf", {31'd0, ovf}, 32'd1);
    check("t3_cnt", sample_cnt, 32'd8);
    check("t3_busy", {31'd0, busy}, 32'd1);
    M_AXIS_TREADY = 1'b1;
    wait_done("t3_done", 50);
    check("t3_ovf_after", {31'd0, ovf}, 32'd1);
    check("t3_sb_empty", sb.size(), 32'd0);

    // 4: sparse ADC input, throttled sink
    M_AXIS_TREADY = 1'b0; adc_valid = 1'b0;
    for (int i = 0; i < 16; i++) expect_beat(16'h1000 + 16'(i), i == 15);
    start(32'd16, 1'b0);
    k = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      adc_valid = (c % 3 == 0);
      adc_data = 16'h1000 + 16'(k);
      if (c % 3 == 0) k++;
      M_AXIS_TREADY = (c % 2 == 1);
      @(posedge ACLK); #1;
    end
    adc_valid = 1'b0; M_AXIS_TREADY = 1'b1;
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_ovf", {31'd0, ovf}, 32'd0);
    check("t4_cnt", sample_cnt, 32'd16);
    check("t4_sb_empty", sb.size(), 32'd0);

    // 5a: second start mid-capture is ignored
    adc_valid = 1'b1; M_AXIS_TREADY = 1'b1;
    for (int i = 0; i < 8; i++) expect_beat(16'(i), i == 7);
    start(32'd8, 1'b1);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    dsize = 32'd3; cr_test = 1'b0; cr_start = 1'b1;
    @(posedge ACLK); #1;
    cr_start = 1'b0;
    check("t5_ignored_cnt", sample_cnt, 32'd3);
    check("t5_ignored_busy", {31'd0, busy}, 32'd1);
    wait_done("t5_done", 50);
    check("t5_cnt", sample_cnt, 32'd8);
    check("t5_sb_empty", sb.size(), 32'd0);

    // 5b: reset mid-packet discards everything
    M_AXIS_TREADY = 1'b0;
    start(32'd20, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge ACLK); #1;
    end
    check("t5_pre_tvalid", {31'd0, M_AXIS_TVALID}, 32'd1);
    ARESET = 1'b1;
    #1;
    check("t5_rst_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_done", {31'd0, done}, 32'd0);
    check("t5_rst_cnt", sample_cnt, 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    M_AXIS_TREADY = 1'b1;

    // 5c: fresh two-beat capture after reset
    expect_beat(16'hA000, 1'b0); expect_beat(16'hA001, 1'b1);
    start(32'd2, 1'b0);
    for (int c = 0; c < 20 && !done; c++) begin
      adc_data = 16'hA000 + 16'(c);
      @(posedge ACLK); #1;
    end
    check("t5c_done", {31'd0, done}, 32'd1);
    check("t5c_cnt", sample_cnt, 32'd2);
    for (int i = 0; i < 4; i++) begin
      @(posedge ACLK); #1;
    end
    check("t5c_sb_empty", sb.size(), 32'd0);
    check("t5c_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc16dv160_input_capture.md
Name: adc16dv160_input_capture

Overview:
- Capture stage fed by the AXI-Lite write block. That block supplies the control values `dsize`, `cr_test` and `cr_start`.
- On a start pulse it collects `dsize` 16-bit samples from the ADC16DV160 deserialised data path, or a counting test pattern.
- Samples are buffered in a small FIFO and emitted as an AXI4-Stream packet, with TLAST on the final beat, toward the DMA.
- Reports busy, done, overflow and a sample count back to the register read path.

Parameters:
- FIFO_DEPTH, 8, FIFO entries; power of two, minimum 4.
- DATA_W, 16, sample width.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- adc_data  in  DATA_W  ADC sample.
- adc_valid  in  1  adc_data valid this cycle; cannot be stalled.
- dsize  in  32  samples per capture; sampled on cr_start.
- cr_test  in  1  1 = test pattern instead of adc_data; sampled on cr_start.
- cr_start  in  1  single-cycle start pulse.
- M_AXIS_TDATA  out  DATA_W  stream data.
- M_AXIS_TVALID  out  1  stream valid.
- M_AXIS_TREADY  in  1  stream ready.
- M_AXIS_TLAST  out  1  last beat of packet.
- busy  out  1  capture or drain in progress.
- done  out  1  sticky; last capture finished.
- ovf  out  1  sticky; last capture aborted on FIFO overflow.
- sample_cnt  out  32  samples accepted in current or last capture.

Behaviour:

Reset (ARESET high, asynchronous):
- State goes to IDLE and the FIFO is emptied.
- All outputs are 0: TVALID, TLAST, TDATA, busy, done, ovf and sample_cnt.
- Reset mid-capture discards all buffered data; no TLAST is emitted.

States: IDLE, CAPTURE, DRAIN.
- IDLE: busy=0 and adc_valid is ignored. On cr_start:
  - Latch dsize into len and cr_test into mode.
  - Clear done, ovf and sample_cnt.
  - If dsize==0, set done=1 on the next cycle and stay in IDLE. No beats are emitted.
  - Otherwise go to CAPTURE.
- CAPTURE: busy=1.
  - Each cycle with adc_valid=1, push one entry and increment sample_cnt.
  - Pushed data is adc_data when mode=0, or sample_cnt[DATA_W-1:0] when mode=1, giving 0,1,2,...
  - The push with sample_cnt==len-1 carries last=1, then go to DRAIN.
- DRAIN: busy=1.
  - When the entry carrying last=1 is handshaked (TVALID&TREADY), go to IDLE with done=1.
- cr_start while busy=1 is ignored and changes nothing.
- dsize and cr_test changes after the start pulse have no effect until the next start.

FIFO:
- Each entry is {last, data}. Occupancy counter runs 0..FIFO_DEPTH.
- TVALID = (occupancy != 0). TDATA and TLAST come from the head entry.
- Pop on TVALID&TREADY.
- Latency: a sample pushed at cycle N is on TDATA with TVALID at cycle N+1 at the earliest.
- Simultaneous push and pop leaves occupancy unchanged.
- AXIS rule: once TVALID is asserted it is held, and TDATA/TLAST are stable, until the handshake.

Overflow (the last slot is reserved so every packet terminates):
- A push that finds post-pop occupancy == FIFO_DEPTH-1 while sample_cnt < len-1 writes that sample with last=1.
- At the same time: set ovf=1, still increment sample_cnt, and go to DRAIN.
- Remaining ADC samples are dropped.
- The stream therefore always ends with TLAST. The packet is short and is flagged by ovf.
- If that same push is the genuine final sample (sample_cnt==len-1), ovf stays 0.

Width and wrap rules:
- sample_cnt is 32-bit, compared against len, and never wraps in practice (len ≤ 2^32-1).
- The test pattern wraps modulo 2^DATA_W.

done:
- Set one cycle after the final handshake, or one cycle after cr_start when dsize==0.
- Cleared only by the next accepted cr_start or by reset.

Test Plan:
1. dsize=4, cr_test=1, adc_valid=1 continuously, TREADY=1 -> beats 0,1,2,3; TLAST only on beat 3; then busy=0, done=1, ovf=0, sample_cnt=4.
2. dsize=0, cr_start -> no TVALID ever; done=1 one cycle later; busy stays 0.
3. FIFO_DEPTH=8, dsize=100, cr_test=1, TREADY=0, adc_valid=1:
   - FIFO holds 8 entries; the 8th (value 7) has TLAST; ovf=1, sample_cnt=8; TVALID is held.
   - Then TREADY=1 -> beats 0..7 drain, followed by done=1.
4. dsize=16, cr_test=0, adc_data = 0x1000+k with adc_valid every 3rd cycle, TREADY high every other cycle -> 16 beats matching the input sequence in order; TLAST on 0x100F; ovf=0; TDATA stable while TVALID&!TREADY.
5. Second cr_start mid-capture (dsize=8) is ignored, and the packet is still 8 beats. In a new capture, ARESET pulsed mid-packet -> TVALID, busy and done drop to 0 immediately. A subsequent dsize=2 capture emits exactly 2 fresh beats.
